// File: rtl/alu_stage.sv
// Handshaked single-issue ALU stage: IDLE -> EXEC|MUL -> DONE -> IDLE.
// Define ALU_STAGE_MUL_EN to build the iterative shift-add multiplier for op 111.
module alu_stage #(
    parameter int WIDTH = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] result,
    output logic             op_err,
    output logic             out_valid,
    input  logic             out_ready
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
                           OP_OR  = 3'b011, OP_XOR = 3'b100, OP_GT  = 3'b101,
                           OP_EQ  = 3'b110, OP_MUL = 3'b111;

`ifdef ALU_STAGE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_result;
    logic [2:0]       r_op;
    logic             r_op_err;
    logic             w_accept, w_to_mul, w_mul_done;
    logic [WIDTH-1:0] w_alu, w_mul_prod;
    logic             w_alu_err;

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_to_mul = MUL_EN && (op == OP_MUL);

    // state register
    always_ff @(posedge clock) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_next = w_to_mul ? S_MUL : S_EXEC;
            S_EXEC: w_next = S_DONE;
            S_MUL:  if (w_mul_done) w_next = S_DONE;
            S_DONE: if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // outputs decoded from state
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    // single-cycle ALU on the latched operands
    always_comb begin
        w_alu     = '0;
        w_alu_err = 1'b0;
        case (r_op)
            OP_ADD: w_alu = r_a + r_b;
            OP_SUB: w_alu = r_a - r_b;
            OP_AND: w_alu = r_a & r_b;
            OP_OR:  w_alu = r_a | r_b;
            OP_XOR: w_alu = r_a ^ r_b;
            OP_GT:  w_alu = WIDTH'($signed(r_a) > $signed(r_b));
            OP_EQ:  w_alu = WIDTH'(r_a == r_b);
            OP_MUL: w_alu_err = !MUL_EN;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_op_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a  <= A;
                r_b  <= B;
                r_op <= op;
            end
            if (r_state == S_EXEC) begin
                r_result <= w_alu;
                r_op_err <= w_alu_err;
            end else if (w_mul_done) begin
                r_result <= w_mul_prod;
                r_op_err <= 1'b0;
            end
        end
    end

`ifdef ALU_STAGE_MUL_EN
    // WIDTH shift-add steps, then one cycle at count==WIDTH to hand the product to result
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(WIDTH);
    logic [WIDTH-1:0] r_cnt, r_acc, r_mcand, r_mplier;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (w_accept && w_to_mul) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= A;
            r_mplier <= B;
        end else if (r_state == S_MUL && r_cnt != CNT_LAST) begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + WIDTH'(1);
        end
    end

    assign w_mul_done = (r_state == S_MUL) && (r_cnt == CNT_LAST);
    assign w_mul_prod = r_acc;
`else
    assign w_mul_done = 1'b0;
    assign w_mul_prod = '0;
`endif

    assign result = r_result;
    assign op_err = r_op_err;

endmodule

// File: tb/tb_alu_stage.sv
// Randomized self-checking bench for alu_stage against an arithmetic reference model.
// Honours ALU_STAGE_MUL_EN the same way as the design.
module tb_alu_stage;
    localparam int W = 6;
    localparam int M = 1 << W;
`ifdef ALU_STAGE_MUL_EN
    localparam int MUL_LAT = W + 1;
`else
    localparam int MUL_LAT = 1;
`endif

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] A = '0, B = '0;
    logic [2:0]   op = '0;
    logic         in_valid = 1'b0, out_ready = 1'b0;
    logic         in_ready, op_err, out_valid;
    logic [W-1:0] result;

    int total = 0;
    int bad = 0;

    alu_stage #(.WIDTH(W)) dut (
        .clock(clock), .reset_n(reset_n), .A(A), .B(B), .op(op),
        .in_valid(in_valid), .in_ready(in_ready), .result(result),
        .op_err(op_err), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clock = ~clock;

    // reference: {err, result} from plain integer arithmetic
    function automatic logic [W:0] ref_model(int a, int b, int o);
        int sa, sb, r;
        bit e;
        sa = (a >= M / 2) ? a - M : a;
        sb = (b >= M / 2) ? b - M : b;
        e  = 1'b0;
        r  = 0;
        case (o)
            0: r = (a + b) % M;
            1: r = (a - b + M) % M;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (sa > sb) ? 1 : 0;
            6: r = (a == b) ? 1 : 0;
            default: begin
`ifdef ALU_STAGE_MUL_EN
                r = (a * b) % M;
`else
                e = 1'b1;
`endif
            end
        endcase
        return {e, W'(r)};
    endfunction

    function automatic int ref_lat(int o);
        return (o == 7) ? MUL_LAT : 1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // one full transaction; operands are scrambled right after the handshake
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o,
                         output logic [W-1:0] res, output logic err, output int lat);
        int n;
        lat = -1;
        res = 'x;
        err = 1'bx;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        if (!in_ready) return;
        A = a; B = b; op = o; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        A = W'($urandom); B = W'($urandom); op = 3'($urandom);
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        if (!out_valid) return;
        lat = n;
        res = result;
        err = op_err;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(); tick();
        total++;
        if (result !== '0 || op_err !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset: result=%0d op_err=%b out_valid=%b in_ready=%b, want 0 0 0 1",
                     result, op_err, out_valid, in_ready);
        end
        reset_n = 1'b1;
        tick();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_random_ops();
        logic [W-1:0] a, b, res;
        logic [2:0]   o;
        logic         err;
        logic [W:0]   exp;
        int           lat;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom); b = W'($urandom); o = 3'($urandom);
            exp = ref_model(int'(a), int'(b), int'(o));
            do_op(a, b, o, res, err, lat);
            total++;
            if (res !== exp[W-1:0] || err !== exp[W] || lat != ref_lat(int'(o))) begin
                bad++;
                $display("FAIL random op=%0d a=%0d b=%0d: got res=%0d err=%b lat=%0d, want %0d %b %0d",
                         o, a, b, res, err, lat, exp[W-1:0], exp[W], ref_lat(int'(o)));
            end
        end
    endtask

    task automatic test_compare();
        logic [W-1:0] res, r;
        logic         err;
        int           lat;
        do_op(6'b110100, 6'd11, 3'b101, res, err, lat);
        total++;
        if (res !== 6'd0 || err !== 1'b0 || lat != 1) begin
            bad++;
            $display("FAIL gt_neg: got res=%0d err=%b lat=%0d, want 0 0 1", res, err, lat);
        end
        do_op(6'd11, 6'b110100, 3'b101, res, err, lat);
        total++;
        if (res !== 6'd1 || err !== 1'b0) begin
            bad++;
            $display("FAIL gt_pos: got res=%0d err=%b, want 1 0", res, err);
        end
        r = W'($urandom);
        do_op(r, r, 3'b110, res, err, lat);
        total++;
        if (res !== 6'd1) begin
            bad++;
            $display("FAIL eq_same: got %0d, want 1", res);
        end
        do_op(r, r, 3'b101, res, err, lat);
        total++;
        if (res !== 6'd0) begin
            bad++;
            $display("FAIL gt_same: got %0d, want 0", res);
        end
        do_op(r, r ^ 6'd1, 3'b110, res, err, lat);
        total++;
        if (res !== 6'd0) begin
            bad++;
            $display("FAIL eq_diff: got %0d, want 0", res);
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] held;
        int           n;
        A = 6'd20; B = 6'd9; op = 3'b001; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        A = '0; B = '0; op = 3'b000;
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        held = result;
        total++;
        if (!out_valid || held !== 6'd11) begin
            bad++;
            $display("FAIL hold_first: out_valid=%b result=%0d, want 1 11", out_valid, held);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || result !== held || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_cycle%0d: out_valid=%b result=%0d in_ready=%b, want 1 %0d 0",
                         i, out_valid, result, in_ready, held);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_midop();
        logic [W-1:0] res;
        logic         err;
        int           lat, seen;
        // abandon a multiply on its third cycle, or an EXEC when there is no multiplier
        A = 6'd7; B = 6'd5; op = (MUL_LAT > 1) ? 3'b111 : 3'b000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (MUL_LAT > 1) begin tick(); tick(); end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen++;
            tick();
        end
        total++;
        if (seen != 0 || in_ready !== 1'b1 || result !== '0) begin
            bad++;
            $display("FAIL reset_midop: out_valid cycles=%0d in_ready=%b result=%0d, want 0 1 0",
                     seen, in_ready, result);
        end
        do_op(6'd30, 6'd40, 3'b000, res, err, lat);
        total++;
        if (res !== 6'd6 || err !== 1'b0 || lat != 1) begin
            bad++;
            $display("FAIL add_after_reset: got res=%0d err=%b lat=%0d, want 6 0 1", res, err, lat);
        end
    endtask

    task automatic test_op7();
        logic [W-1:0] res;
        logic         err;
        int           lat;
        logic [W:0]   exp;
        exp = ref_model(7, 5, 7);
        do_op(6'd7, 6'd5, 3'b111, res, err, lat);
        total++;
        if (res !== exp[W-1:0] || err !== exp[W] || lat != MUL_LAT) begin
            bad++;
            $display("FAIL op7_7x5: got res=%0d err=%b lat=%0d, want %0d %b %0d",
                     res, err, lat, exp[W-1:0], exp[W], MUL_LAT);
        end
        exp = ref_model(9, 9, 7);
        do_op(6'd9, 6'd9, 3'b111, res, err, lat);
        total++;
        if (res !== exp[W-1:0] || err !== exp[W]) begin
            bad++;
            $display("FAIL op7_9x9: got res=%0d err=%b, want %0d %b", res, err, exp[W-1:0], exp[W]);
        end
        do_op(6'd63, 6'd1, 3'b000, res, err, lat);
        total++;
        if (res !== 6'd0 || err !== 1'b0) begin
            bad++;
            $display("FAIL add_wrap: got res=%0d err=%b, want 0 0", res, err);
        end
    endtask

    // in_valid and out_ready held high: accepts spaced exactly 3 cycles, results in order
    task automatic test_back_to_back();
        logic [W:0] expq[$];
        logic [W:0] exp;
        int         cyc, last_acc, gaps_bad, outs;
        logic [2:0] o;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        last_acc  = -1;
        gaps_bad  = 0;
        outs      = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            o = 3'($urandom_range(0, 6));
            A = W'($urandom); B = W'($urandom); op = o;
            #1;
            if (in_ready) begin
                expq.push_back(ref_model(int'(A), int'(B), int'(o)));
                if (last_acc >= 0 && cyc - last_acc != 3) gaps_bad++;
                last_acc = cyc;
            end
            if (out_valid) begin
                outs++;
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_spurious: result=%0d with nothing outstanding", result);
                end else begin
                    exp = expq.pop_front();
                    if (result !== exp[W-1:0] || op_err !== exp[W]) begin
                        bad++;
                        $display("FAIL b2b_result: got %0d err=%b, want %0d %b",
                                 result, op_err, exp[W-1:0], exp[W]);
                    end
                end
            end
            @(posedge clock);
            #0;
        end
        in_valid = 1'b0;
        #1;
        tick();
        out_ready = 1'b0;
        total++;
        if (gaps_bad != 0 || outs < 12) begin
            bad++;
            $display("FAIL b2b_rate: bad gaps=%0d outputs=%0d, want 0 and >=12", gaps_bad, outs);
        end
    endtask

    initial begin
        test_reset();
        test_random_ops();
        test_compare();
        test_hold();
        test_reset_midop();
        test_op7();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_stage.md
ALU_STAGE -- requirements
Module: alu_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, meaning the operand and result width in bits.
REQ-002 The block SHALL have port clock, input, 1 bit, meaning the single rising-edge clock.
REQ-003 The block SHALL have port reset_n, input, 1 bit, meaning a synchronous active-low reset.
REQ-004 The block SHALL have port A, input, WIDTH bits, meaning operand A in two's complement.
REQ-005 The block SHALL have port B, input, WIDTH bits, meaning operand B in two's complement.
REQ-006 The block SHALL have port op, input, 3 bits, meaning the opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 GREATER, 110 EQUAL, 111 MUL.
REQ-007 The block SHALL have port in_valid, input, 1 bit, meaning the upstream operation is valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit, meaning the block can accept an operation.
REQ-009 The block SHALL have port result, output, WIDTH bits, meaning the registered operation result.
REQ-010 The block SHALL have port op_err, output, 1 bit, meaning the opcode was unsupported; qualified by out_valid.
REQ-011 The block SHALL have port out_valid, output, 1 bit, meaning result and op_err are valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit, meaning downstream accepts the result.

Function
REQ-013 The FSM SHALL use four states, IDLE, EXEC, MUL and DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 A handshake (in_valid && in_ready at a rising edge) SHALL latch A, B and op; the next state SHALL be MUL for op 111 with MUL compiled in, else EXEC.
REQ-015 EXEC SHALL last one cycle, register result and op_err, and go to DONE, so out_valid rises after the edge following the handshake.
REQ-016 ADD and SUB SHALL be modulo 2^WIDTH with carry and overflow discarded; AND, OR and XOR SHALL be bitwise.
REQ-017 GREATER SHALL return 1 zero-extended when A > B as signed values, else 0; equal operands SHALL return 0.
REQ-018 EQUAL SHALL return 1 zero-extended when A == B, else 0.
REQ-019 MUL SHALL be an iterative shift-add over exactly WIDTH cycles in state MUL using a WIDTH-bit iteration counter, then go to DONE with result equal to the low WIDTH bits of A*B.
REQ-020 In DONE, result, op_err and out_valid=1 SHALL hold stable until out_ready=1; on that edge the FSM SHALL return to IDLE and out_valid SHALL clear.
REQ-021 Inputs A, B and op SHALL be ignored outside a handshake, and changes after the handshake SHALL NOT affect an operation in progress.
REQ-022 Throughput SHALL be at most one operation per 3 cycles for non-MUL ops; no IDLE bypass from DONE is permitted.

Reset
REQ-023 reset_n=0 at a rising edge SHALL force IDLE, result=0, op_err=0, out_valid=0, iteration counter=0, and in_ready=1 on release.
REQ-024 Reset asserted during EXEC, MUL or DONE SHALL abandon the operation with no out_valid pulse.

Configuration
REQ-025 With macro ALU_STAGE_MUL_EN defined, op 111 SHALL perform MUL per REQ-019 with op_err=0.
REQ-026 Without ALU_STAGE_MUL_EN, op 111 SHALL take the EXEC path with result=0 and op_err=1, and no multiplier or counter logic SHALL be synthesised.

Verification
REQ-027 GREATER with A=6'b110100 (-12) and B=11 -> result 6'd0 and out_valid one cycle after accept.
REQ-028 GREATER with A=11 and B=6'b110100 -> result 6'd1; EQUAL with A=B=random -> 1; GREATER with A=B -> 0.
REQ-029 With MUL_EN, MUL with A=7 and B=5 -> result 6'd35 with out_valid WIDTH+1 cycles after accept; A=9 and B=9 -> 6'd17 (81 mod 64).
REQ-030 Hold out_ready=0 for 5 cycles in DONE -> result and out_valid stable and in_ready=0; out_ready=1 -> IDLE on the next edge.
REQ-031 Assert reset_n=0 on MUL cycle 3 -> out_valid stays 0, in_ready=1 after release, and the next ADD 30+40 -> 6'd6.
REQ-032 Without MUL_EN, op 111 -> result 0 and op_err=1; ADD 63+1 -> 6'd0 with op_err=0.
